// File: rtl/sprite_line_fetcher_pkg.sv
// Shared types for the sprite line fetcher: active-list entry layout, FSM states and
// line-buffer slice format.
package sprite_line_fetcher_pkg;

  localparam int unsigned ACT_VRAM_AW   = 18;
  localparam int unsigned ACT_LB_AW     = 12;
  localparam int unsigned TILE_CNT_W    = 6;
  localparam int unsigned TILE_PX       = 8;
  localparam int unsigned TILE_SCREEN_W = 16;

  typedef struct packed {
    logic                    x_flip;
    logic [TILE_CNT_W-1:0]   tile_count;
    logic [ACT_VRAM_AW-1:0]  tilemap_addr;
  } active_tilemap_addr_t;

  typedef struct packed {
    logic [ACT_LB_AW-1:0]    lb_addr;
    logic [ACT_VRAM_AW-1:0]  tile_bitmap_addr;
  } active_bitmap_addr_t;

  typedef enum logic [2:0] {
    StIdle, StAddr, StLatch, StTmap, StBmp, StWrite, StDrain
  } fetch_state_t;

  typedef struct packed {
    logic [3:0]                palette;
    logic [TILE_PX-1:0][3:0]   color;
  } lb_slice_t;

endpackage

// File: rtl/sprite_slice_unpack.sv
// Combinational unpack of one 4bpp bitmap row into 8 palette/color pixels plus a
// transparency mask (color 0 is transparent).
module sprite_slice_unpack
  import sprite_line_fetcher_pkg::*;
(
  input  logic [31:0] row,
  input  logic [3:0]  palette,
  input  logic        x_flip,
  output logic [63:0] lb_data,
  output logic [7:0]  lb_mask
);

  lb_slice_t slice;

  always_comb begin
    slice   = '0;
    lb_data = '0;
    lb_mask = '0;
    slice.palette = palette;
    for (int p = 0; p < TILE_PX; p++) begin
      slice.color[p] = x_flip ? row[4*(TILE_PX-1-p) +: 4] : row[4*p +: 4];
    end
    for (int p = 0; p < TILE_PX; p++) begin
      lb_data[8*p +: 8] = {slice.palette, slice.color[p]};
      lb_mask[p]        = |slice.color[p];
    end
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Walks the per-line active-sprite list, fetches tilemap entries and bitmap rows from VRAM
// and writes 8-pixel slices into the line buffer. Optional stats: SPRITE_FETCH_STATS_EN.
module sprite_line_fetcher
  import sprite_line_fetcher_pkg::*;
#(
  parameter int unsigned VRAM_AW  = ACT_VRAM_AW,
  parameter int unsigned LB_AW    = ACT_LB_AW,
  parameter int unsigned LB_WIDTH = 1280
) (
  input  logic                 clk_draw,
  input  logic                 rst_draw,
  input  logic                 line,
  output logic [8:0]           sprite_index,
  input  logic                 act_valid,
  input  active_tilemap_addr_t act_tilemap,
  input  active_bitmap_addr_t  act_bitmap,
  output logic                 vram_req,
  output logic [VRAM_AW-1:0]   vram_addr,
  input  logic                 vram_ack,
  input  logic [31:0]          vram_rdata,
  output logic                 lb_we,
  output logic [LB_AW-1:0]     lb_x,
  output logic [63:0]          lb_data,
  output logic [7:0]           lb_mask,
  output logic                 busy
`ifdef SPRITE_FETCH_STATS_EN
  ,
  output logic [8:0]           stat_sprites,
  output logic                 stat_overrun
`endif
);

  fetch_state_t         state_q, state_d;
  logic [8:0]           sprite_index_q, sprite_index_d;
  active_tilemap_addr_t tm_q, tm_d;
  active_bitmap_addr_t  bm_q, bm_d;
  logic [TILE_CNT_W-1:0] i_q, i_d;
  logic [TILE_CNT_W:0]   ntiles_q, ntiles_d;
  logic [8:0]           tile_index_q, tile_index_d;
  logic [3:0]           palette_q, palette_d;
  logic [31:0]          row_q, row_d;
  logic                 req_q, req_d;
  logic [VRAM_AW-1:0]   addr_q, addr_d;
  logic                 restart_q, restart_d;

  logic [TILE_CNT_W-1:0] tile_sel;
  logic [VRAM_AW-1:0]    tmap_addr, bmp_addr;
  logic [TILE_CNT_W:0]   i_next;
  logic                  lb_x_ok;

  assign tile_sel  = tm_q.x_flip ? tm_q.tile_count - i_q : i_q;
  assign tmap_addr = VRAM_AW'(tm_q.tilemap_addr) + VRAM_AW'(tile_sel);
  assign bmp_addr  = VRAM_AW'(bm_q.tile_bitmap_addr) + VRAM_AW'(tile_index_q);
  assign i_next    = (TILE_CNT_W+1)'(i_q) + (TILE_CNT_W+1)'(1);
  assign lb_x      = LB_AW'(bm_q.lb_addr) + LB_AW'(i_q * TILE_SCREEN_W);
  assign lb_x_ok   = 32'(lb_x) < LB_WIDTH;

  assign sprite_index = sprite_index_q;
  assign vram_req     = req_q;
  assign vram_addr    = addr_q;
  assign busy         = (state_q != StIdle);

  sprite_slice_unpack u_unpack (
    .row     (row_q),
    .palette (palette_q),
    .x_flip  (tm_q.x_flip),
    .lb_data (lb_data),
    .lb_mask (lb_mask)
  );

  always_comb begin
    state_d        = state_q;
    sprite_index_d = sprite_index_q;
    tm_d           = tm_q;
    bm_d           = bm_q;
    i_d            = i_q;
    ntiles_d       = ntiles_q;
    tile_index_d   = tile_index_q;
    palette_d      = palette_q;
    row_d          = row_q;
    req_d          = req_q;
    addr_d         = addr_q;
    restart_d      = restart_q;
    lb_we          = 1'b0;
    if (line && state_q != StDrain) begin
      // An ack landing with the line pulse completes the read, so no drain is needed.
      if (req_q && !vram_ack) begin
        state_d   = StDrain;
        restart_d = 1'b1;
      end else begin
        req_d          = 1'b0;
        sprite_index_d = '0;
        state_d        = StAddr;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: state_d = StLatch;
        StLatch: begin
          if (!act_valid) begin
            state_d = StIdle;
          end else begin
            tm_d     = act_tilemap;
            bm_d     = act_bitmap;
            i_d      = '0;
            ntiles_d = (TILE_CNT_W+1)'(act_tilemap.tile_count) + (TILE_CNT_W+1)'(1);
            state_d  = StTmap;
          end
        end
        StTmap: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = tmap_addr;
          end else if (vram_ack) begin
            req_d        = 1'b0;
            tile_index_d = vram_rdata[8:0];
            palette_d    = vram_rdata[15:12];
            state_d      = StBmp;
          end
        end
        StBmp: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = bmp_addr;
          end else if (vram_ack) begin
            req_d   = 1'b0;
            row_d   = vram_rdata;
            state_d = StWrite;
          end
        end
        StWrite: begin
          lb_we = lb_x_ok;
          i_d   = i_next[TILE_CNT_W-1:0];
          if (i_next == ntiles_q) begin
            if (sprite_index_q == 9'd511) begin
              state_d = StIdle;
            end else begin
              sprite_index_d = sprite_index_q + 9'd1;
              state_d        = StAddr;
            end
          end else begin
            state_d = StTmap;
          end
        end
        StDrain: begin
          if (line) restart_d = 1'b1;
          if (req_q && vram_ack) begin
            req_d     = 1'b0;
            restart_d = 1'b0;
            if (restart_q || line) begin
              sprite_index_d = '0;
              state_d        = StAddr;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q        <= StIdle;
      sprite_index_q <= '0;
      tm_q           <= '0;
      bm_q           <= '0;
      i_q            <= '0;
      ntiles_q       <= '0;
      tile_index_q   <= '0;
      palette_q      <= '0;
      row_q          <= '0;
      req_q          <= 1'b0;
      addr_q         <= '0;
      restart_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sprite_index_q <= sprite_index_d;
      tm_q           <= tm_d;
      bm_q           <= bm_d;
      i_q            <= i_d;
      ntiles_q       <= ntiles_d;
      tile_index_q   <= tile_index_d;
      palette_q      <= palette_d;
      row_q          <= row_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      restart_q      <= restart_d;
    end
  end

`ifdef SPRITE_FETCH_STATS_EN
  logic       sprite_done;
  logic [8:0] done_cnt_q;
  logic [8:0] stat_sprites_q;
  logic       stat_overrun_q;

  assign sprite_done  = (state_q == StWrite) && !line && (i_next == ntiles_q);
  assign stat_sprites = stat_sprites_q;
  assign stat_overrun = stat_overrun_q;

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      done_cnt_q     <= '0;
      stat_sprites_q <= '0;
      stat_overrun_q <= 1'b0;
    end else if (line) begin
      stat_sprites_q <= done_cnt_q;
      stat_overrun_q <= (state_q != StIdle);
      done_cnt_q     <= '0;
    end else if (sprite_done) begin
      done_cnt_q <= done_cnt_q + 9'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: VRAM responder with programmable ack latency,
// active-list model, write capture, table of single-sprite vectors plus corner sequences.
module tb_sprite_line_fetcher;
  import sprite_line_fetcher_pkg::*;

  localparam logic [17:0] TM = 18'h100;
  localparam logic [17:0] BM = 18'h200;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 line;
  logic [8:0]           sprite_index;
  logic                 act_valid;
  active_tilemap_addr_t act_tilemap;
  active_bitmap_addr_t  act_bitmap;
  logic                 vram_req;
  logic [17:0]          vram_addr;
  logic                 vram_ack;
  logic [31:0]          vram_rdata;
  logic                 lb_we;
  logic [11:0]          lb_x;
  logic [63:0]          lb_data;
  logic [7:0]           lb_mask;
  logic                 busy;
`ifdef SPRITE_FETCH_STATS_EN
  logic [8:0]           stat_sprites;
  logic                 stat_overrun;
`endif

  sprite_line_fetcher dut (
    .clk_draw     (clk),
    .rst_draw     (rst),
    .line         (line),
    .sprite_index (sprite_index),
    .act_valid    (act_valid),
    .act_tilemap  (act_tilemap),
    .act_bitmap   (act_bitmap),
    .vram_req     (vram_req),
    .vram_addr    (vram_addr),
    .vram_ack     (vram_ack),
    .vram_rdata   (vram_rdata),
    .lb_we        (lb_we),
    .lb_x         (lb_x),
    .lb_data      (lb_data),
    .lb_mask      (lb_mask),
    .busy         (busy)
`ifdef SPRITE_FETCH_STATS_EN
    ,
    .stat_sprites (stat_sprites),
    .stat_overrun (stat_overrun)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]          mem [0:1023];
  int                   ack_delay = 0;
  int                   act_count = 0;
  active_tilemap_addr_t act_tm [0:3];
  active_bitmap_addr_t  act_bm [0:3];

  typedef struct packed {
    logic [11:0] x;
    logic [63:0] d;
    logic [7:0]  m;
  } wr_t;

  logic [17:0] rd_log [$];
  wr_t         wr_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // VRAM responder: ack after ack_delay cycles of request, one cycle wide.
  initial begin
    int wcnt = 0;
    vram_ack   = 1'b0;
    vram_rdata = '0;
    forever begin
      @(negedge clk);
      if (vram_ack) begin
        vram_ack = 1'b0;
      end else if (vram_req) begin
        if (wcnt >= ack_delay) begin
          vram_ack   = 1'b1;
          vram_rdata = mem[vram_addr[9:0]];
          rd_log.push_back(vram_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Active-list model: valid when index < count.
  initial begin
    act_valid   = 1'b0;
    act_tilemap = '0;
    act_bitmap  = '0;
    forever begin
      @(negedge clk);
      act_valid = (int'(sprite_index) < act_count);
      if (sprite_index < 9'd4) begin
        act_tilemap = act_tm[sprite_index[1:0]];
        act_bitmap  = act_bm[sprite_index[1:0]];
      end
    end
  end

  // Write capture; a write must never coincide with a line pulse.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (lb_we) begin
        wr_log.push_back('{lb_x, lb_data, lb_mask});
        chk("we_vs_line", {63'd0, line}, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_line();
    @(negedge clk);
    line = 1'b1;
    @(negedge clk);
    line = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic set_sprite(input int idx, input logic flip, input logic [5:0] tc,
                            input logic [11:0] lb);
    act_tm[idx] = '{x_flip: flip, tile_count: tc, tilemap_addr: TM};
    act_bm[idx] = '{lb_addr: lb, tile_bitmap_addr: BM};
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
  endtask

  typedef struct packed {
    logic        flip;
    logic [11:0] lb;
    logic [15:0] tmw;
    logic [31:0] bmp;
    logic [3:0]  nwr;
    logic [11:0] x;
    logic [63:0] data;
    logic [7:0]  mask;
  } vec_t;

  vec_t vecs [6];

  initial begin
    wr_t         w;
    logic [17:0] exp_rd [6];
    logic [11:0] exp_x  [3];
    logic [63:0] exp_d  [3];
    int          n;
    logic        drop;

    vecs[0] = '{1'b0, 12'd100,  16'h3005, 32'h87654321, 4'd1, 12'd100,  64'h3837363534333231, 8'hFF};
    vecs[1] = '{1'b1, 12'd100,  16'h3005, 32'h87654321, 4'd1, 12'd100,  64'h3132333435363738, 8'hFF};
    vecs[2] = '{1'b0, 12'd100,  16'h3005, 32'h00F000F0, 4'd1, 12'd100,  64'h30303F3030303F30, 8'h22};
    vecs[3] = '{1'b1, 12'd0,    16'hA007, 32'h0000000F, 4'd1, 12'd0,    64'hAFA0A0A0A0A0A0A0, 8'h80};
    vecs[4] = '{1'b0, 12'd1279, 16'h3005, 32'h87654321, 4'd1, 12'd1279, 64'h3837363534333231, 8'hFF};
    vecs[5] = '{1'b0, 12'd1280, 16'h3005, 32'h87654321, 4'd0, 12'd0,    64'h0,                8'h00};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      act_tm[i] = '0;
      act_bm[i] = '0;
    end

    rst  = 1'b1;
    line = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",   {63'd0, busy},     64'd0);
    chk("rst_req",    {63'd0, vram_req}, 64'd0);
    chk("rst_we",     {63'd0, lb_we},    64'd0);
    chk("rst_index",  {55'd0, sprite_index}, 64'd0);
    chk("rst_addr",   {46'd0, vram_addr}, 64'd0);
    chk("rst_mask",   {56'd0, lb_mask},  64'd0);

    // Single-sprite, single-tile table.
    act_count = 1;
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      set_sprite(0, vecs[v].flip, 6'd0, vecs[v].lb);
      mem[TM[9:0]] = {16'd0, vecs[v].tmw};
      mem[BM[9:0] + {1'b0, vecs[v].tmw[8:0]}] = vecs[v].bmp;
      pulse_line();
      wait_idle($sformatf("v%0d_done", v));
      chk($sformatf("v%0d_nwr", v), 64'(wr_log.size()), 64'(vecs[v].nwr));
      chk($sformatf("v%0d_nrd", v), 64'(rd_log.size()), 64'd2);
      if (vecs[v].nwr != 0) begin
        w = (wr_log.size() > 0) ? wr_log[0] : '0;
        chk($sformatf("v%0d_x", v),    {52'd0, w.x}, {52'd0, vecs[v].x});
        chk($sformatf("v%0d_data", v), w.d,          vecs[v].data);
        chk($sformatf("v%0d_mask", v), {56'd0, w.m}, {56'd0, vecs[v].mask});
      end
    end

    // Three flipped tiles: tilemap walked backwards, slices advance by 16.
    clear_logs();
    mem[TM[9:0]]      = 32'h3005;
    mem[TM[9:0] + 1]  = 32'h3006;
    mem[TM[9:0] + 2]  = 32'h3007;
    mem[BM[9:0] + 5]  = 32'h87654321;
    mem[BM[9:0] + 6]  = 32'h11111111;
    mem[BM[9:0] + 7]  = 32'h22222222;
    set_sprite(0, 1'b1, 6'd2, 12'd100);
    pulse_line();
    wait_idle("flip3_done");
    exp_rd[0] = TM + 2; exp_rd[1] = BM + 7;
    exp_rd[2] = TM + 1; exp_rd[3] = BM + 6;
    exp_rd[4] = TM;     exp_rd[5] = BM + 5;
    exp_x[0] = 12'd100; exp_x[1] = 12'd116; exp_x[2] = 12'd132;
    exp_d[0] = 64'h3232323232323232;
    exp_d[1] = 64'h3131313131313131;
    exp_d[2] = 64'h3132333435363738;
    chk("flip3_nrd", 64'(rd_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flip3_rd%0d", i), {46'd0, (i < rd_log.size()) ? rd_log[i] : 18'h3FFFF},
          {46'd0, exp_rd[i]});
    end
    chk("flip3_nwr", 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      w = (i < wr_log.size()) ? wr_log[i] : '0;
      chk($sformatf("flip3_x%0d", i), {52'd0, w.x}, {52'd0, exp_x[i]});
      chk($sformatf("flip3_d%0d", i), w.d, exp_d[i]);
    end

    // Right edge: second slice at 1288 is fetched but not written.
    clear_logs();
    set_sprite(0, 1'b0, 6'd1, 12'd1272);
    pulse_line();
    wait_idle("edge_done");
    chk("edge_nrd", 64'(rd_log.size()), 64'd4);
    chk("edge_nwr", 64'(wr_log.size()), 64'd1);
    w = (wr_log.size() > 0) ? wr_log[0] : '0;
    chk("edge_x", {52'd0, w.x}, 64'd1272);

    // Line arrives while a slow read is outstanding: request held, data dropped, restart at 0.
    clear_logs();
    ack_delay = 10;
    set_sprite(0, 1'b0, 6'd0, 12'd100);
    pulse_line();
    n = 0;
    while (!vram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_req_up", {63'd0, vram_req}, 64'd1);
    repeat (3) @(negedge clk);
    pulse_line();
    n = 0;
    drop = 1'b0;
    while (rd_log.size() == 0 && n < 40) begin
      @(negedge clk);
      #1;
      if (!vram_req) drop = 1'b1;
      n++;
    end
    chk("drain_req_held", {63'd0, drop}, 64'd0);
    chk("drain_nowr", 64'(wr_log.size()), 64'd0);
    wait_idle("drain_done");
    chk("drain_nrd", 64'(rd_log.size()), 64'd3);
    chk("drain_rd1", {46'd0, (rd_log.size() > 1) ? rd_log[1] : 18'h3FFFF}, {46'd0, TM});
    chk("drain_nwr", 64'(wr_log.size()), 64'd1);
    w = (wr_log.size() > 0) ? wr_log[0] : '0;
    chk("drain_x", {52'd0, w.x}, 64'd100);
    ack_delay = 0;

    // Empty list: no VRAM traffic, busy drops quickly.
    clear_logs();
    act_count = 0;
    pulse_line();
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("empty_busy_fall", {63'd0, (n <= 3)}, 64'd1);
    chk("empty_nrd", 64'(rd_log.size()), 64'd0);

`ifdef SPRITE_FETCH_STATS_EN
    act_count = 3;
    mem[TM[9:0]] = 32'h3005;
    set_sprite(0, 1'b0, 6'd0, 12'd0);
    set_sprite(1, 1'b0, 6'd0, 12'd16);
    set_sprite(2, 1'b0, 6'd0, 12'd32);
    pulse_line();
    wait_idle("stats_done");
    pulse_line();
    chk("stat_sprites", {55'd0, stat_sprites}, 64'd3);
    chk("stat_overrun", {63'd0, stat_overrun}, 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
